div_seq: RTL
============

# div_seq

Iterative multi-cycle divide sequencer for the execute stage of the five-stage MIPS pipeline. It accepts a DIV/DIVU request from the ALU path and runs a 32-iteration restoring division. It raises `stall_div` to freeze the pipeline while the operation is in progress and delivers a 64-bit {remainder, quotient} result for the HI/LO write path.

## Interface
- No parameters; widths are fixed by package constants.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: divide request, held high by the stalled E stage.
- `signed_div` in 1: 1 selects DIV (signed), 0 selects DIVU. Sampled only with an accepted `start`.
- `annul` in 1: cancels the operation in progress and suppresses `start`. Driven by pipeline flush.
- `opdata1` in 32: dividend, sampled only with an accepted `start`.
- `opdata2` in 32: divisor, sampled only with an accepted `start`.
- `result` out 64: [63:32] remainder (to HI), [31:0] quotient (to LO). Reset value 0.
- `ready` out 1: one-cycle pulse; `result` is valid in that cycle. Reset value 0.
- `stall_div` out 1: `start & ~ready & ~annul`, combinational. Reset value 0 (`start` is low during reset).

## Operation
- States (2-bit): IDLE, BY_ZERO, ON, END.
- **IDLE**:
  - `start & ~annul`: latch `signed_div`, the operands, and magnitudes |a|, |b|. Magnitudes use two's-complement negation only when `signed_div` is set and bit 31 is set.
  - `opdata2 == 0` → BY_ZERO.
  - Otherwise → ON. Load working register {rem = 0, quo = |a|} and clear the iteration counter.
- **BY_ZERO**: → END; `result` is loaded with 0.
- **ON**, each cycle, one step:
  - Shift {rem, quo} left by 1.
  - Compute the 33-bit trial = {1'b0, rem_shifted} − {1'b0, |b|}.
  - If there is no borrow: rem = trial[31:0] and quo[0] = 1.
  - The counter increments.
  - After the 32nd step → END. `result` is loaded with sign-fixed values:
    - quotient is negated if signed and the operand signs differ;
    - remainder is negated if signed and the dividend is negative.
- **END**: `ready` = 1; → IDLE unconditionally. A `start` still high in END does not restart the divider.
- `annul` in BY_ZERO or ON → IDLE at the next edge. `ready` is never raised for that operation and `result` is unchanged.
- `start` or operand changes outside IDLE are ignored.
- `result` holds its value until the next END.
- Overflow case 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0. There is no trap.

## Timing
- Accept edge = the end of cycle 0, in which `start` is seen in IDLE.
- Normal path: ON occupies cycles 1–32; END/`ready` is in cycle 33; IDLE from cycle 34.
- Divide by zero: BY_ZERO in cycle 1; `ready` in cycle 2.
- `stall_div` is high in cycles 0–32 (normal) or 0–1 (zero divisor), and low in the `ready` cycle so the E stage advances with `result`.
- A new `start` is accepted no earlier than cycle 34, giving back-to-back divides one bubble.
- Asynchronous `rst` at any point: state IDLE, counter 0, `result` 0, `ready` 0, immediately.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - In IDLE, on accept with divisor ≠ 0 and |a| < |b| (unsigned magnitude compare), go directly to END.
  - `result` = {`opdata1`, 32'h0}, and `ready` is in cycle 1.
- Undefined: every nonzero-divisor divide takes the full 33-cycle path, with an identical `result`.

## Structure
- Package `div_pkg`:
  - state enum (IDLE=2'b00, BY_ZERO=2'b01, ON=2'b10, END=2'b11);
  - `DIV_ITER` = 32;
  - `DIV_CNT_W` = 6;
  - `DIV_RES_W` = 64.
- Sub-module `div_step`: combinational single restoring iteration, with inputs {rem, quo} and |b|, and output next {rem, quo}. Instantiated once; the FSM and registers stay in `div_seq`.

## Test plan
- DIVU 100 / 7, `start` held → `stall_div` high in cycles 0–32, `ready` in cycle 33, `result` = {32'd2, 32'd14}.
- DIV −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- DIV 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}.
- DIVU 5 / 0 → `ready` in cycle 2, `result` = 0, `stall_div` low from cycle 2.
- DIVU 100 / 7 with `annul` pulsed in cycle 10 → IDLE in cycle 11, no `ready`, `result` keeps its previous value. A new DIVU 9 / 3 in cycle 12 → `ready` in cycle 45 with {0, 3}.
- `start` held through END, then a second DIVU 20 / 6 from cycle 34 → no restart in cycle 34's predecessor. `ready` in cycle 67, `result` = {2, 3}.
- `rst` asserted in cycle 15 of a divide → outputs go to 0 asynchronously; resume from IDLE.
- DIVU 3 / 10:
  - with `DIV_EARLY_OUT_EN`, `ready` in cycle 1, `result` = {3, 0};
  - without it, `ready` in cycle 33 with the same `result`.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divide sequencer.
package div_pkg;

  localparam int DIV_ITER  = 32;
  localparam int DIV_CNT_W = 6;
  localparam int DIV_RES_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BY_ZERO = 2'b01,
    ON      = 2'b10,
    END     = 2'b11
  } div_state_e;

  // Two's-complement magnitude; only signed operands with bit 31 set are negated.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on the {rem, quo} working register.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_RES_W-1:0] work,
  input  logic [31:0]          divisor,
  output logic [DIV_RES_W-1:0] next
);

  logic [DIV_RES_W-1:0] shifted;
  logic [33:0]          trial;

  always_comb begin
    // NOTE: every output gets a default before the conditional update, so no latch is inferred.
    shifted = {work[DIV_RES_W-2:0], 1'b0};
    // The bit shifted out of rem is kept so unsigned divisors above 2^31 still divide correctly.
    trial   = {1'b0, work[DIV_RES_W-1:31]} - {2'b00, divisor};
    next    = shifted;
    if (!trial[33]) begin
      next = {trial[31:0], shifted[31:1], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// 32-iteration restoring DIV/DIVU sequencer with pipeline stall and annul.
// Optional DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_seq
  import div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic                 annul,
  input  logic [31:0]          opdata1,
  input  logic [31:0]          opdata2,
  output logic [DIV_RES_W-1:0] result,
  output logic                 ready,
  output logic                 stall_div
);

  localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(DIV_ITER - 1);

  div_state_e           state;
  logic [DIV_CNT_W-1:0] cnt;
  logic [DIV_RES_W-1:0] work;
  logic [DIV_RES_W-1:0] step_next;
  logic [31:0]          divisor;
  logic                 signed_r;
  logic                 a_neg;
  logic                 b_neg;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic        q_neg;
  logic        r_neg;

  assign abs_a = magnitude(opdata1, signed_div);
  assign abs_b = magnitude(opdata2, signed_div);

  assign q_neg   = signed_r & (a_neg ^ b_neg);
  assign r_neg   = signed_r & a_neg;
  assign quo_fix = q_neg ? (~step_next[31:0] + 32'd1) : step_next[31:0];
  assign rem_fix = r_neg ? (~step_next[63:32] + 32'd1) : step_next[63:32];

  assign stall_div = start & ~ready & ~annul;

  div_step u_step (
    .work    (work),
    .divisor (divisor),
    .next    (step_next)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      signed_r <= 1'b0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      result   <= '0;
      ready    <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !annul) begin
            signed_r <= signed_div;
            a_neg    <= opdata1[31];
            b_neg    <= opdata2[31];
            divisor  <= abs_b;
            work     <= {32'h0, abs_a};
            cnt      <= '0;
            if (opdata2 == 32'h0) begin
              state <= BY_ZERO;
`ifdef DIV_EARLY_OUT_EN
            end else if (abs_a < abs_b) begin
              state  <= END;
              result <= {opdata1, 32'h0};
              ready  <= 1'b1;
`endif
            end else begin
              state <= ON;
            end
          end
        end
        BY_ZERO: begin
          if (annul) begin
            state <= IDLE;
          end else begin
            state  <= END;
            result <= '0;
            ready  <= 1'b1;
          end
        end
        ON: begin
          if (annul) begin
            state <= IDLE;
          end else begin
            work <= step_next;
            cnt  <= cnt + DIV_CNT_W'(1);
            if (cnt == LAST_CNT) begin
              state  <= END;
              result <= {rem_fix, quo_fix};
              ready  <= 1'b1;
            end
          end
        end
        // A start still held here is deliberately ignored; the E stage advances this cycle.
        END:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
